// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the memory it fills.
package imem_loader_pkg;

    localparam int ADDR_W_DEF      = 12;
    localparam int DEPTH_WORDS_DEF = 1024;
    localparam int BYTES_PER_WORD  = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in, memory write port and status out. master = loader side.
interface imem_loader_if #(
    parameter int ADDR_W = imem_loader_pkg::ADDR_W_DEF
);
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;

    modport master (
        input  start, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error
    );

    modport slave (
        output start, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error
    );
endinterface

// File: rtl/imem_loader_word_packer.sv
// Packs bytes little-endian into a 32-bit shadow word. 'word' already includes
// the byte being accepted this cycle, and 'full' flags the byte that completes it,
// so the caller can capture a finished word on the same edge.
module imem_loader_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        full
);
    logic [BYTES_PER_WORD-1:0][7:0] shadow;
    logic [BYTES_PER_WORD-1:0][7:0] merged;
    logic [1:0]                     byte_idx;

    // Merge the incoming byte into its lane so the completed word is visible early.
    always_comb begin
        merged = shadow;
        if (byte_valid) merged[byte_idx] = byte_data;
        full = byte_valid && (byte_idx == 2'd3);
    end

    assign word = merged;

    // Lane register and 2-bit index; the index wraps naturally after lane 3.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow   <= '0;
            byte_idx <= 2'd0;
        end else if (clear) begin
            shadow   <= '0;
            byte_idx <= 2'd0;
        end else if (byte_valid) begin
            shadow[byte_idx] <= byte_data;
            byte_idx         <= byte_idx + 2'd1;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// Fills the instruction memory from a byte stream: 16-bit little-endian word
// count header, then little-endian 32-bit words. Holds the core in reset meanwhile.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF
) (
    input logic           clk,
    input logic           rst,
    imem_loader_if.master bus
);
    if (DEPTH_WORDS != 2 ** (ADDR_W - 2)) begin : g_bad_depth
        $error("imem_loader: DEPTH_WORDS must equal 2**(ADDR_W-2)");
    end

    state_t            state;
    logic [15:0]       len;
    logic [ADDR_W-2:0] word_cnt;
    logic [15:0]       cnt_nx;
    logic [15:0]       len_full;
    logic              xfer;
    logic              can_start;
    logic              pk_full;
    logic [31:0]       pk_word;

    assign xfer      = bus.in_valid && bus.in_ready;
    assign can_start = bus.start && (state == S_IDLE || state == S_DONE || state == S_ERR);
    assign cnt_nx    = 16'(word_cnt) + 16'd1;
    assign len_full  = {bus.in_data, len[7:0]};

    imem_loader_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (can_start),
        .byte_valid (xfer && (state == S_DATA)),
        .byte_data  (bus.in_data),
        .word       (pk_word),
        .full       (pk_full)
    );

    // Load FSM; all outputs registered and set on the transition into each state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            len           <= '0;
            word_cnt      <= '0;
            bus.in_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.cpu_hold  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.error     <= 1'b0;
        end else begin
            bus.done   <= 1'b0;
            bus.mem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.start) begin
                        state        <= S_LEN_LO;
                        word_cnt     <= '0;
                        bus.error    <= 1'b0;
                        bus.cpu_hold <= 1'b1;
                        bus.busy     <= 1'b1;
                        bus.in_ready <= 1'b1;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        len[7:0] <= bus.in_data;
                        state    <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        len[15:8] <= bus.in_data;
                        if (len_full == 16'd0) begin
                            state        <= S_DONE;
                            bus.done     <= 1'b1;
                            bus.cpu_hold <= 1'b0;
                            bus.busy     <= 1'b0;
                            bus.in_ready <= 1'b0;
                        end else if (len_full > 16'(DEPTH_WORDS)) begin
                            state        <= S_ERR;
                            bus.error    <= 1'b1;
                            bus.cpu_hold <= 1'b0;
                            bus.busy     <= 1'b0;
                            bus.in_ready <= 1'b0;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    // Fourth byte: capture address and finished word for the write cycle.
                    if (pk_full) begin
                        state         <= S_WRITE;
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= {word_cnt[ADDR_W-3:0], 2'b00};
                        bus.mem_wdata <= pk_word;
                        bus.in_ready  <= 1'b0;
                    end
                end
                S_WRITE: begin
                    word_cnt <= cnt_nx[ADDR_W-2:0];
                    if (cnt_nx == len) begin
                        state        <= S_DONE;
                        bus.done     <= 1'b1;
                        bus.cpu_hold <= 1'b0;
                        bus.busy     <= 1'b0;
                    end else begin
                        state        <= S_DATA;
                        bus.in_ready <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte streams in, observed memory writes and
// status compared against hand-computed expectations.
module tb_imem_loader;
    localparam int ADDR_W = 12;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(ADDR_W)) ifc ();

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH_WORDS(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    // Write/status monitor, sampled on the falling edge.
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];
    int                done_cnt = 0;
    int                viol_cnt = 0;

    always @(negedge clk) begin
        if (ifc.mem_we) begin
            wr_addr_q.push_back(ifc.mem_addr);
            wr_data_q.push_back(ifc.mem_wdata);
        end
        if (ifc.done) done_cnt++;
        // while loading, in_ready is low exactly in the write cycles
        if (ifc.busy && (ifc.in_ready == ifc.mem_we)) viol_cnt++;
        if (ifc.busy != ifc.cpu_hold) viol_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at a falling edge after the byte transferred.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        ifc.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        ifc.in_valid = 1'b1;
        ifc.in_data  = b;
        t = 0;
        while (!ifc.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!ifc.in_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_timeout: in_ready stuck low, byte %h", b);
        end else begin
            @(negedge clk);
        end
        ifc.in_valid = 1'b0;
    endtask

    task automatic send_stream(input bq_t s, input int maxgap);
        foreach (s[i]) send_byte(s[i], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
    endtask

    task automatic pulse_start();
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
    endtask

    // Checks the two-word program landed at 0x000/0x004 with one done pulse.
    task automatic chk_two_words(input string tag, input int wb, input int db);
        repeat (3) @(negedge clk);
        chk({tag, "_nwr"},   32'(wr_addr_q.size() - wb), 32'd2);
        chk({tag, "_a0"},    32'(wr_addr_q[wb]),          32'h000);
        chk({tag, "_d0"},    wr_data_q[wb],               32'h00A00513);
        chk({tag, "_a1"},    32'(wr_addr_q[wb+1]),        32'h004);
        chk({tag, "_d1"},    wr_data_q[wb+1],             32'h00100593);
        chk({tag, "_done"},  32'(done_cnt - db),          32'd1);
        chk({tag, "_hold"},  32'(ifc.cpu_hold),           32'd0);
        chk({tag, "_busy"},  32'(ifc.busy),               32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rdy"},   32'(ifc.in_ready),  32'd0);
        chk({tag, "_we"},    32'(ifc.mem_we),    32'd0);
        chk({tag, "_addr"},  32'(ifc.mem_addr),  32'd0);
        chk({tag, "_wdata"}, ifc.mem_wdata,      32'd0);
        chk({tag, "_hold"},  32'(ifc.cpu_hold),  32'd0);
        chk({tag, "_busy"},  32'(ifc.busy),      32'd0);
        chk({tag, "_done"},  32'(ifc.done),      32'd0);
        chk({tag, "_err"},   32'(ifc.error),     32'd0);
    endtask

    bq_t prog2 = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    bq_t head2 = '{8'h02, 8'h00, 8'h13, 8'h05};
    bq_t tail2 = '{8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};

    initial begin
        int wb, db;
        bq_t big;
        logic [31:0] w;

        ifc.start    = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_data  = 8'h00;

        // reset state
        #12;
        chk_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // plain two-word load
        wb = wr_addr_q.size(); db = done_cnt;
        pulse_start();
        chk("l2_hold_on", 32'(ifc.cpu_hold), 32'd1);
        chk("l2_busy_on", 32'(ifc.busy),     32'd1);
        send_stream(prog2, 0);
        chk_two_words("l2", wb, db);

        // same stream with random valid gaps
        wb = wr_addr_q.size(); db = done_cnt;
        pulse_start();
        send_stream(prog2, 3);
        chk_two_words("gap", wb, db);

        // zero-length header
        wb = wr_addr_q.size(); db = done_cnt;
        pulse_start();
        send_stream('{8'h00, 8'h00}, 0);
        repeat (3) @(negedge clk);
        chk("zero_nwr",  32'(wr_addr_q.size() - wb), 32'd0);
        chk("zero_done", 32'(done_cnt - db),          32'd1);

        // full 1024-word image: word i = C0DE0000 | i
        big = '{8'h00, 8'h04};
        for (int i = 0; i < 1024; i++) begin
            w = 32'hC0DE0000 | 32'(i);
            for (int k = 0; k < 4; k++) big.push_back(w[8*k +: 8]);
        end
        wb = wr_addr_q.size(); db = done_cnt;
        pulse_start();
        send_stream(big, 0);
        repeat (3) @(negedge clk);
        chk("full_nwr",   32'(wr_addr_q.size() - wb), 32'd1024);
        chk("full_d0",    wr_data_q[wb],              32'hC0DE0000);
        chk("full_alast", 32'(wr_addr_q[wb+1023]),    32'hFFC);
        chk("full_dlast", wr_data_q[wb+1023],         32'hC0DE03FF);
        chk("full_done",  32'(done_cnt - db),         32'd1);

        // 1025 words: error, no writes
        wb = wr_addr_q.size(); db = done_cnt;
        pulse_start();
        send_stream('{8'h01, 8'h04}, 0);
        repeat (4) @(negedge clk);
        chk("ovf_err",  32'(ifc.error),              32'd1);
        chk("ovf_nwr",  32'(wr_addr_q.size() - wb),  32'd0);
        chk("ovf_rdy",  32'(ifc.in_ready),           32'd0);
        chk("ovf_busy", 32'(ifc.busy),               32'd0);
        chk("ovf_hold", 32'(ifc.cpu_hold),           32'd0);
        chk("ovf_done", 32'(done_cnt - db),          32'd0);

        // restart from error
        wb = wr_addr_q.size(); db = done_cnt;
        pulse_start();
        chk("rerr_clr", 32'(ifc.error), 32'd0);
        send_stream(prog2, 0);
        chk_two_words("rerr", wb, db);

        // start during DATA is ignored
        wb = wr_addr_q.size(); db = done_cnt;
        pulse_start();
        send_stream(head2, 0);
        pulse_start();
        chk("ign_busy", 32'(ifc.busy),     32'd1);
        chk("ign_rdy",  32'(ifc.in_ready), 32'd1);
        send_stream(tail2, 0);
        chk_two_words("ign", wb, db);

        // asynchronous reset mid-word, then a clean reload
        pulse_start();
        send_stream(head2, 0);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("mid");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wb = wr_addr_q.size(); db = done_cnt;
        pulse_start();
        send_stream(prog2, 0);
        chk_two_words("rld", wb, db);

        chk("rdy_we_hold", 32'(viol_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart to the CPU's read-only, byte-addressed instruction memory: fills it from a byte stream (e.g. a debug UART) before the core runs.
- Parses a 2-byte word-count header, packs the following bytes into little-endian 32-bit words and drives the memory write port at consecutive word-aligned byte addresses.
- Holds the core in reset while loading and reports done or error.

Parameters:
- ADDR_W, 12, byte-address width of the instruction memory (4 KiB).
- DEPTH_WORDS, 1024, capacity in 32-bit words; must equal 2**(ADDR_W-2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- in_valid  input  1  a byte is offered on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts in_data this cycle; a transfer occurs when in_valid && in_ready.
- mem_we  output  1  instruction-memory write strobe, one cycle per word.
- mem_addr  output  ADDR_W  byte address of the word written; always a multiple of 4.
- mem_wdata  output  32  word: first byte received in [7:0], fourth byte in [31:24].
- cpu_hold  output  1  keeps the core in reset while a load is in progress.
- busy  output  1  a load is in progress.
- done  output  1  one-cycle pulse when the last word has been written.
- error  output  1  sticky; word count exceeds DEPTH_WORDS.

Behaviour:
- Reset (asynchronous, rst=1): state IDLE.
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, busy=0, done=0, error=0.
  - Internal word counter, byte index and length register all cleared.
- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR.
- IDLE/DONE/ERR + start:
  - Go to LEN_LO.
  - Clear error, the address counter and the byte index.
  - Set cpu_hold=1 and busy=1 from the next cycle.
- start in any other state is ignored.
- LEN_LO: in_ready=1; on a transfer, latch the byte into len[7:0] and go to LEN_HI.
- LEN_HI: in_ready=1; on a transfer, len[15:8]=byte, then:
  - len==0: go to DONE.
  - len>DEPTH_WORDS: go to ERR.
  - otherwise: go to DATA.
- DATA: in_ready=1; each transfer writes the byte into lane byte_idx of the shadow word, then byte_idx increments (2-bit).
  - The transfer with byte_idx==3 moves to WRITE.
  - Bytes are never dropped.
  - in_valid gaps of any length are allowed.
- WRITE (exactly one cycle):
  - mem_we=1, mem_addr=word_cnt*4, mem_wdata=shadow word, in_ready=0.
  - Next cycle: word_cnt increments; if word_cnt+1==len go to DONE, else return to DATA.
  - Latency: mem_we rises on the cycle after the 4th byte's transfer.
- DONE:
  - On entry: done=1 for one cycle; cpu_hold=0, busy=0, in_ready=0.
  - Stay until start.
- ERR:
  - error=1 (sticky), cpu_hold=0, busy=0, in_ready=0, no memory writes.
  - Stay until start or rst.
- mem_addr/mem_wdata hold their last values when mem_we=0.
- Address arithmetic: word_cnt is ADDR_W-1 bits wide. Because len≤DEPTH_WORDS, the highest address is 4*(DEPTH_WORDS-1) and the counter never wraps during a load.
- Asserting rst mid-load aborts immediately to the reset state. The partially written memory is not restored.
- A truncated stream (in_valid stays low) stalls indefinitely in DATA with cpu_hold=1; no timeout.

Decomposition:
- Shared package:
  - State enum and its encoding.
  - BYTES_PER_WORD=4.
  - Default ADDR_W/DEPTH_WORDS, so the memory and the loader agree on size.
- One natural sub-module, word_packer: byte-lane shadow register plus 2-bit byte index, with inputs byte_valid/byte_data/clear and output word plus full.
- FSM, counters and the write port stay in imem_loader.

Test Plan:
- Load of 2 words: reset, start, stream 02 00 13 05 A0 00 93 05 10 00.
  - Exactly two mem_we pulses: addr 0x000 data 0x00A00513, then addr 0x004 data 0x00100593.
  - done pulses once after the second write; cpu_hold is high from start until done.
- Back-pressure and gaps: same stream with random in_valid gaps.
  - Identical writes.
  - in_ready=0 exactly in the WRITE cycles.
  - No byte is lost or duplicated.
- Boundaries:
  - Header 00 00: done with no writes.
  - Header 00 04 (1024 words): last write at addr 0xFFC, then done.
  - Header 01 04 (1025): error=1, no mem_we, in_ready=0.
- Reset mid-load: assert rst after the 2nd data byte of word 1.
  - All outputs return to reset values immediately, without waiting for a clk edge.
  - A following start plus a full stream loads correctly from addr 0.
- Ignored start and restart after error:
  - A start pulse during DATA leaves the state and counters unchanged.
  - A start from ERR clears error and accepts a new valid load.
